// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings and widths for the data-memory arbiter.
package dmem_arbiter_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way grant: round-robin against last_grant, or fixed CPU priority.
module rr_arb2
  import dmem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       cpu_priority,
  output logic       grant,
  output logic       any_req
);

  always_comb begin
    grant = PORT_CPU;
    if (req == 2'b11) begin
      grant = cpu_priority ? PORT_CPU : ~last_grant;
    end else if (req[1]) begin
      grant = PORT_DMA;
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/dmem_arbiter.sv
// Serialises CPU and DMA accesses to a single-port data memory: IDLE -> ACCESS -> DONE.
// Request sampled in IDLE is acked two cycles later; all outputs registered.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DEPTH        = 256,
  parameter bit CPU_PRIORITY = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic              cpu_err,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic              dma_err,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_datain,
  input  logic [DATA_W-1:0] mem_dataout,
  output logic              busy
);

  state_t state, state_nxt;

  logic              last_grant;
  logic              grant;
  logic              any_req;
  logic              cmd_id;
  logic              cmd_we;
  logic              cmd_oor;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_in_range;
  logic [DATA_W-1:0] rd_val;

  rr_arb2 u_arb (
    .req          ({dma_req, cpu_req}),
    .last_grant   (last_grant),
    .cpu_priority (CPU_PRIORITY),
    .grant        (grant),
    .any_req      (any_req)
  );

  assign sel_we       = (grant == PORT_DMA) ? dma_we    : cpu_we;
  assign sel_addr     = (grant == PORT_DMA) ? dma_addr  : cpu_addr;
  assign sel_wdata    = (grant == PORT_DMA) ? dma_wdata : cpu_wdata;
  assign sel_in_range = 32'(sel_addr) < 32'(DEPTH);

  // Writes and out-of-range accesses return zero data.
  assign rd_val = (cmd_we || cmd_oor) ? '0 : mem_dataout;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= PORT_DMA;
      cmd_id     <= PORT_CPU;
      cmd_we     <= 1'b0;
      cmd_oor    <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_datain <= '0;
      cpu_ack    <= 1'b0;
      cpu_err    <= 1'b0;
      cpu_rdata  <= '0;
      dma_ack    <= 1'b0;
      dma_err    <= 1'b0;
      dma_rdata  <= '0;
      busy       <= 1'b0;
    end else begin
      busy    <= (state_nxt != IDLE);
      cpu_ack <= 1'b0;
      cpu_err <= 1'b0;
      dma_ack <= 1'b0;
      dma_err <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            cmd_id     <= grant;
            cmd_we     <= sel_we;
            cmd_oor    <= ~sel_in_range;
            mem_addr   <= sel_addr;
            mem_datain <= sel_wdata;
            mem_write  <= sel_we & sel_in_range;
          end
        end
        ACCESS: begin
          // Ack is registered here so it is visible throughout DONE.
          mem_write <= 1'b0;
          if (cmd_id == PORT_DMA) begin
            dma_ack   <= 1'b1;
            dma_err   <= cmd_oor;
            dma_rdata <= rd_val;
          end else begin
            cpu_ack   <= 1'b1;
            cpu_err   <= cmd_oor;
            cpu_rdata <= rd_val;
          end
        end
        DONE: begin
          last_grant <= cmd_id;
        end
        default: begin
          mem_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench: round-robin instance with a memory model, plus a CPU-priority instance.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [15:0] cpu_addr, dma_addr;
  logic [31:0] cpu_wdata, dma_wdata;

  logic        cpu_ack, cpu_err, dma_ack, dma_err, mem_write, busy;
  logic [31:0] cpu_rdata, dma_rdata, mem_datain, mem_dataout;
  logic [15:0] mem_addr;

  logic        p_cpu_ack, p_cpu_err, p_dma_ack, p_dma_err, p_mem_write, p_busy;
  logic [31:0] p_cpu_rdata, p_dma_rdata, p_mem_datain;
  logic [15:0] p_mem_addr;
  logic [31:0] p_mem_dataout = 32'h0;

  logic [31:0] mem [0:255];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DEPTH(256), .CPU_PRIORITY(1'b0)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_err(dma_err), .dma_rdata(dma_rdata),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_datain(mem_datain),
    .mem_dataout(mem_dataout), .busy(busy)
  );

  dmem_arbiter #(.DEPTH(256), .CPU_PRIORITY(1'b1)) dut_prio (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(p_cpu_ack), .cpu_err(p_cpu_err), .cpu_rdata(p_cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(p_dma_ack), .dma_err(p_dma_err), .dma_rdata(p_dma_rdata),
    .mem_write(p_mem_write), .mem_addr(p_mem_addr), .mem_datain(p_mem_datain),
    .mem_dataout(p_mem_dataout), .busy(p_busy)
  );

  // Single-port memory: synchronous write, combinational read.
  assign mem_dataout = mem[mem_addr[7:0]];
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[7:0]] <= mem_datain;
  end

  typedef struct {
    logic        port;
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int          lat, wcnt;
    logic [31:0] rd;
    logic        er, got, oth;
    logic [15:0] waddr;
    lat = 0; wcnt = 0; rd = '0; er = 1'b0; got = 1'b0; oth = 1'b0; waddr = '0;
    if (v.port) begin
      dma_req = 1'b1; dma_we = v.we; dma_addr = v.addr; dma_wdata = v.wdata;
    end else begin
      cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
    end
    for (int c = 1; c <= 8 && !got; c++) begin
      tick();
      if (mem_write) begin
        wcnt++;
        waddr = mem_addr;
      end
      if (v.port ? cpu_ack : dma_ack) oth = 1'b1;
      if (v.port ? dma_ack : cpu_ack) begin
        got = 1'b1;
        lat = c;
        rd  = v.port ? dma_rdata : cpu_rdata;
        er  = v.port ? dma_err : cpu_err;
      end
    end
    cpu_req = 1'b0;
    dma_req = 1'b0;
    chk($sformatf("vec%0d latency", idx), lat, 2);
    chk($sformatf("vec%0d rdata", idx), rd, v.exp_rdata);
    chk($sformatf("vec%0d err", idx), {31'b0, er}, {31'b0, v.exp_err});
    chk($sformatf("vec%0d write_cycles", idx), wcnt, (v.we && v.addr < 16'd256) ? 1 : 0);
    chk($sformatf("vec%0d other_ack", idx), {31'b0, oth}, 32'd0);
    if (wcnt > 0) chk($sformatf("vec%0d write_addr", idx), {16'b0, waddr}, {16'b0, v.addr});
    tick();
  endtask

  initial begin
    int          n, both, pcpu, pdma, plat, acks;
    logic [3:0]  order;
    int          when [4];

    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
    do_reset();

    chk("reset cpu_ack", {31'b0, cpu_ack}, 32'd0);
    chk("reset dma_ack", {31'b0, dma_ack}, 32'd0);
    chk("reset errs", {30'b0, cpu_err, dma_err}, 32'd0);
    chk("reset mem_write", {31'b0, mem_write}, 32'd0);
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset mem_addr", {16'b0, mem_addr}, 32'd0);
    chk("reset mem_datain", mem_datain, 32'd0);
    chk("reset cpu_rdata", cpu_rdata, 32'd0);
    chk("reset dma_rdata", dma_rdata, 32'd0);

    //         port we  addr    wdata         exp_rdata     err
    vecs[0] = '{1'b0, 1'b1, 16'd5,   32'hDEADBEEF, 32'h00000000, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 16'd5,   32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 16'd300, 32'h12345678, 32'h00000000, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 16'd300, 32'h0,        32'h00000000, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 16'd255, 32'hA5A5A5A5, 32'h00000000, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 16'd255, 32'h0,        32'hA5A5A5A5, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 16'd256, 32'hFFFFFFFF, 32'h00000000, 1'b1};
    vecs[7] = '{1'b1, 1'b0, 16'd5,   32'h0,        32'hDEADBEEF, 1'b0};
    vecs[8] = '{1'b1, 1'b0, 16'd0,   32'h0,        32'h00000000, 1'b0};
    vecs[9] = '{1'b0, 1'b1, 16'd9,   32'h00000099, 32'h00000000, 1'b0};
    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // Address changed during ACCESS must not affect the in-flight access.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'd5;
    tick();
    chk("midchg mem_addr", {16'b0, mem_addr}, 32'd5);
    cpu_addr = 16'd9;
    tick();
    chk("midchg ack", {31'b0, cpu_ack}, 32'd1);
    chk("midchg rdata", cpu_rdata, 32'hDEADBEEF);
    tick();
    chk("midchg ack drop", {31'b0, cpu_ack}, 32'd0);
    tick();
    chk("midchg new addr", {16'b0, mem_addr}, 32'd9);
    tick();
    chk("midchg second ack", {31'b0, cpu_ack}, 32'd1);
    chk("midchg second rdata", cpu_rdata, 32'h00000099);
    cpu_req = 1'b0;
    tick();

    // Both ports held: round-robin alternates, priority instance starves DMA.
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'd5;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'd255;
    n = 0; both = 0; pcpu = 0; pdma = 0; order = '0;
    for (int i = 0; i < 4; i++) when[i] = 0;
    for (int c = 1; c <= 11; c++) begin
      tick();
      if (cpu_ack && dma_ack) both++;
      if ((cpu_ack || dma_ack) && n < 4) begin
        order[n] = dma_ack;
        when[n]  = c;
        n++;
      end
      if (p_cpu_ack) pcpu++;
      if (p_dma_ack) pdma++;
    end
    chk("rr ack count", n, 4);
    chk("rr order", {28'b0, order}, 32'b1010);
    chk("rr ack0 cycle", when[0], 2);
    chk("rr ack1 cycle", when[1], 5);
    chk("rr ack2 cycle", when[2], 8);
    chk("rr ack3 cycle", when[3], 11);
    chk("rr simultaneous acks", both, 0);
    chk("prio cpu acks", pcpu, 4);
    chk("prio dma acks", pdma, 0);
    cpu_req = 1'b0;
    plat = 0;
    for (int c = 1; c <= 6 && plat == 0; c++) begin
      tick();
      if (p_dma_ack) plat = c;
    end
    chk("prio dma after drop", plat, 3);
    dma_req = 1'b0;
    tick();
    tick();

    // Reset during ACCESS of a CPU write aborts with no ack.
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'd7; cpu_wdata = 32'h55;
    tick();
    chk("abort access mem_write", {31'b0, mem_write}, 32'd1);
    chk("abort access busy", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    chk("abort busy", {31'b0, busy}, 32'd0);
    chk("abort mem_write", {31'b0, mem_write}, 32'd0);
    chk("abort cpu_ack", {31'b0, cpu_ack}, 32'd0);
    reset = 1'b0;
    cpu_req = 1'b0;
    acks = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (cpu_ack) acks++;
    end
    chk("abort no late ack", acks, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
